// File: rtl/av2_obu_front_end_if.sv
// Bundles the bitstream beat, OBU descriptor and frame header handshakes
// between the OBU front end and its producer/consumers.
interface av2_obu_front_end_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic [3:0]            obu_type;
  logic [31:0]           obu_size;
  logic                  obu_valid;
  logic                  obu_ready;
  logic [1:0]            frame_type;
  logic [15:0]           frame_width;
  logic [15:0]           frame_height;
  logic [7:0]            qindex;
  logic                  header_valid;
  logic                  header_ready;
  logic                  error;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, obu_ready, header_ready,
    output s_axis_tready, obu_type, obu_size, obu_valid, frame_type,
           frame_width, frame_height, qindex, header_valid, error
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, obu_ready, header_ready,
    input  s_axis_tready, obu_type, obu_size, obu_valid, frame_type,
           frame_width, frame_height, qindex, header_valid, error
  );
endinterface

// File: rtl/av2_obu_front_end.sv
// Parses the OBU header, LEB128 size and leading frame header fields from the
// first beat of each OBU and presents them as descriptor/header records.
//
// state | meaning
// IDLE  | waiting for the first beat of an OBU
// HOLD  | descriptor presented, stream stalled until obu_ready
// SKIP  | dropping remaining beats of the current OBU up to tlast
module av2_obu_front_end #(
  parameter int DATA_WIDTH = 128
) (
  input logic clk,
  input logic rst,
  av2_obu_front_end_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, SKIP} state_t;

  state_t state, state_nxt;

  logic        load_obu, err_set, last_q;
  logic        malformed, is_hdr;
  logic [3:0]  p, q, nsz;
  logic [7:0]  lb0, lb1, lb2, lb3;
  logic [7:0]  fb1, fb2, fb3, fb4, fb5;
  logic [1:0]  ft_dec;
  logic [31:0] size_dec;

  logic [3:0]  obu_type_q;
  logic [31:0] obu_size_q;
  logic [1:0]  frame_type_q;
  logic [15:0] frame_width_q, frame_height_q;
  logic [7:0]  qindex_q;
  logic        header_valid_q, error_q;

  function automatic logic [7:0] byte_at(input logic [DATA_WIDTH-1:0] d, input logic [3:0] idx);
    return d[8*idx +: 8];
  endfunction

  function automatic logic [1:0] bits2_at(input logic [DATA_WIDTH-1:0] d, input logic [3:0] idx);
    return d[8*idx +: 2];
  endfunction

  function automatic logic [15:0] plus1_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  // First-beat parse: extension byte skipped, then up to four LEB128 size bytes,
  // then the frame header fields start at offset q.
  always_comb begin
    p        = bus.s_axis_tdata[2] ? 4'd2 : 4'd1;
    lb0      = byte_at(bus.s_axis_tdata, p);
    lb1      = byte_at(bus.s_axis_tdata, p + 4'd1);
    lb2      = byte_at(bus.s_axis_tdata, p + 4'd2);
    lb3      = byte_at(bus.s_axis_tdata, p + 4'd3);
    size_dec = '0;
    nsz      = 4'd0;
    malformed = bus.s_axis_tdata[7];
    if (bus.s_axis_tdata[1]) begin
      nsz           = 4'd1;
      size_dec[6:0] = lb0[6:0];
      if (lb0[7]) begin
        nsz            = 4'd2;
        size_dec[13:7] = lb1[6:0];
        if (lb1[7]) begin
          nsz             = 4'd3;
          size_dec[20:14] = lb2[6:0];
          if (lb2[7]) begin
            nsz             = 4'd4;
            size_dec[27:21] = lb3[6:0];
            malformed       = malformed | lb3[7];
          end
        end
      end
    end
    q      = p + nsz;
    ft_dec = bits2_at(bus.s_axis_tdata, q);
    fb1    = byte_at(bus.s_axis_tdata, q + 4'd1);
    fb2    = byte_at(bus.s_axis_tdata, q + 4'd2);
    fb3    = byte_at(bus.s_axis_tdata, q + 4'd3);
    fb4    = byte_at(bus.s_axis_tdata, q + 4'd4);
    fb5    = byte_at(bus.s_axis_tdata, q + 4'd5);
    is_hdr = (bus.s_axis_tdata[6:3] == 4'd3) || (bus.s_axis_tdata[6:3] == 4'd6);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_obu  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_axis_tvalid) begin
          if (malformed) begin
            err_set = 1'b1;
            if (!bus.s_axis_tlast) state_nxt = SKIP;
          end else begin
            load_obu  = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: if (bus.obu_ready) state_nxt = last_q ? IDLE : SKIP;
      SKIP: if (bus.s_axis_tvalid && bus.s_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obu_type_q     <= '0;
      obu_size_q     <= '0;
      last_q         <= 1'b0;
      frame_type_q   <= '0;
      frame_width_q  <= '0;
      frame_height_q <= '0;
      qindex_q       <= '0;
      header_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      error_q <= err_set;
      if (load_obu) begin
        obu_type_q <= bus.s_axis_tdata[6:3];
        obu_size_q <= size_dec;
        last_q     <= bus.s_axis_tlast;
      end
      // A new header load takes priority over a same-cycle consumer release.
      if (load_obu && is_hdr) begin
        frame_type_q   <= ft_dec;
        frame_width_q  <= plus1_sat({fb2, fb1});
        frame_height_q <= plus1_sat({fb4, fb3});
        qindex_q       <= fb5;
        header_valid_q <= 1'b1;
      end else if (bus.header_ready) begin
        header_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_axis_tready = !rst && (state != HOLD);
  assign bus.obu_valid     = (state == HOLD);
  assign bus.obu_type      = obu_type_q;
  assign bus.obu_size      = obu_size_q;
  assign bus.frame_type    = frame_type_q;
  assign bus.frame_width   = frame_width_q;
  assign bus.frame_height  = frame_height_q;
  assign bus.qindex        = qindex_q;
  assign bus.header_valid  = header_valid_q;
  assign bus.error         = error_q;
endmodule

// File: tb/tb_av2_obu_front_end.sv
// Directed bench for av2_obu_front_end: hand-built first beats with
// hand-computed descriptor and header fields.
module tb_av2_obu_front_end;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  av2_obu_front_end_if #(.DATA_WIDTH(128)) bus ();

  av2_obu_front_end #(.DATA_WIDTH(128)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic last,
                           input logic [7:0] b0, b1, b2, b3, b4, b5,
                           input logic [7:0] b6, b7, b8, b9, b10, b11);
    @(negedge clk);
    bus.s_axis_tdata  = {32'h0, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = last;
    chk("tready_at_beat", 32'(bus.s_axis_tready), 32'd1);
    tick();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic pulse_obu_ready();
    @(negedge clk);
    bus.obu_ready = 1'b1;
    tick();
    bus.obu_ready = 1'b0;
    chk("obu_valid_after_ready", 32'(bus.obu_valid), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.obu_ready     = 1'b0;
    bus.header_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("rst_obu_valid", 32'(bus.obu_valid), 32'd0);
    chk("rst_header_valid", 32'(bus.header_valid), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_obu_type", 32'(bus.obu_type), 32'd0);
    chk("rst_obu_size", bus.obu_size, 32'd0);
    chk("rst_frame_type", 32'(bus.frame_type), 32'd0);
    chk("rst_width", 32'(bus.frame_width), 32'd0);
    chk("rst_height", 32'(bus.frame_height), 32'd0);
    chk("rst_qindex", 32'(bus.qindex), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("tready_after_rst", 32'(bus.s_axis_tready), 32'd1);

    // Frame header OBU, single beat, 64x64 key frame
    send_beat(1'b1, 8'h1A, 8'h06, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t1_obu_valid", 32'(bus.obu_valid), 32'd1);
    chk("t1_obu_type", 32'(bus.obu_type), 32'd3);
    chk("t1_obu_size", bus.obu_size, 32'd6);
    chk("t1_frame_type", 32'(bus.frame_type), 32'd0);
    chk("t1_width", 32'(bus.frame_width), 32'd64);
    chk("t1_height", 32'(bus.frame_height), 32'd64);
    chk("t1_qindex", 32'(bus.qindex), 32'd128);
    chk("t1_header_valid", 32'(bus.header_valid), 32'd1);
    chk("t1_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("t1_error", 32'(bus.error), 32'd0);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_obu_valid_held", 32'(bus.obu_valid), 32'd1);
    end
    pulse_obu_ready();
    chk("t2_tready_idle", 32'(bus.s_axis_tready), 32'd1);
    chk("t2_header_valid_held", 32'(bus.header_valid), 32'd1);
    @(negedge clk);
    bus.header_ready = 1'b1;
    tick();
    bus.header_ready = 1'b0;
    chk("t2_header_valid_cleared", 32'(bus.header_valid), 32'd0);

    // Frame OBU with extension byte, two-byte LEB128 size, 1920x1080 inter
    send_beat(1'b0, 8'h36, 8'h55, 8'hC8, 8'h01, 8'h01, 8'h7F, 8'h07, 8'h37, 8'h04, 8'hFF, 8'h00, 8'h00);
    chk("t3_obu_type", 32'(bus.obu_type), 32'd6);
    chk("t3_obu_size", bus.obu_size, 32'd200);
    chk("t3_frame_type", 32'(bus.frame_type), 32'd1);
    chk("t3_width", 32'(bus.frame_width), 32'd1920);
    chk("t3_height", 32'(bus.frame_height), 32'd1080);
    chk("t3_qindex", 32'(bus.qindex), 32'd255);
    chk("t3_header_valid", 32'(bus.header_valid), 32'd1);
    pulse_obu_ready();
    chk("t3_skip_tready", 32'(bus.s_axis_tready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_beat(i == 2, 8'h12, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("t3_skip_no_desc", 32'(bus.obu_valid), 32'd0);
    end
    chk("t3_type_after_skip", 32'(bus.obu_type), 32'd6);

    // Non-header OBU; trailing bytes ignored, header record untouched
    send_beat(1'b1, 8'h0A, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C);
    chk("t4_obu_valid", 32'(bus.obu_valid), 32'd1);
    chk("t4_obu_type", 32'(bus.obu_type), 32'd1);
    chk("t4_obu_size", bus.obu_size, 32'd2);
    chk("t4_frame_type", 32'(bus.frame_type), 32'd1);
    chk("t4_width", 32'(bus.frame_width), 32'd1920);
    chk("t4_height", 32'(bus.frame_height), 32'd1080);
    chk("t4_qindex", 32'(bus.qindex), 32'd255);
    chk("t4_header_valid", 32'(bus.header_valid), 32'd1);
    pulse_obu_ready();

    // No size field, saturating width, load coincident with header_ready
    bus.header_ready = 1'b1;
    send_beat(1'b1, 8'h18, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t5_header_valid_load_wins", 32'(bus.header_valid), 32'd1);
    chk("t5_obu_type", 32'(bus.obu_type), 32'd3);
    chk("t5_obu_size", bus.obu_size, 32'd0);
    chk("t5_frame_type", 32'(bus.frame_type), 32'd2);
    chk("t5_width_sat", 32'(bus.frame_width), 32'hFFFF);
    chk("t5_height", 32'(bus.frame_height), 32'd1);
    chk("t5_qindex", 32'(bus.qindex), 32'h10);
    tick();
    bus.header_ready = 1'b0;
    chk("t5_header_valid_cleared", 32'(bus.header_valid), 32'd0);
    pulse_obu_ready();

    // Forbidden bit set on a multi-beat OBU
    send_beat(1'b0, 8'h9A, 8'h06, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t6_error_pulse", 32'(bus.error), 32'd1);
    chk("t6_obu_valid", 32'(bus.obu_valid), 32'd0);
    chk("t6_tready", 32'(bus.s_axis_tready), 32'd1);
    chk("t6_type_kept", 32'(bus.obu_type), 32'd3);
    tick();
    chk("t6_error_one_cycle", 32'(bus.error), 32'd0);
    send_beat(1'b0, 8'h1A, 8'h06, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t6_drop_mid", 32'(bus.obu_valid), 32'd0);
    send_beat(1'b1, 8'h1A, 8'h06, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t6_drop_last", 32'(bus.obu_valid), 32'd0);
    chk("t6_error_quiet", 32'(bus.error), 32'd0);

    // Fourth LEB128 byte still continuing, single beat: stays in IDLE
    send_beat(1'b1, 8'h12, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t7_leb_error", 32'(bus.error), 32'd1);
    chk("t7_leb_no_desc", 32'(bus.obu_valid), 32'd0);
    send_beat(1'b1, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t7_leb4_valid", 32'(bus.obu_valid), 32'd1);
    chk("t7_leb4_size", bus.obu_size, 32'h0FFF_FFFF);
    chk("t7_leb4_type", 32'(bus.obu_type), 32'd2);
    chk("t7_leb4_no_error", 32'(bus.error), 32'd0);
    pulse_obu_ready();

    // Reset while in SKIP, then a clean parse
    send_beat(1'b0, 8'h32, 8'h06, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t8_header_valid", 32'(bus.header_valid), 32'd1);
    pulse_obu_ready();
    chk("t8_skip_tready", 32'(bus.s_axis_tready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t8_rst_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("t8_rst_obu_valid", 32'(bus.obu_valid), 32'd0);
    chk("t8_rst_header_valid", 32'(bus.header_valid), 32'd0);
    chk("t8_rst_error", 32'(bus.error), 32'd0);
    chk("t8_rst_obu_type", 32'(bus.obu_type), 32'd0);
    chk("t8_rst_obu_size", bus.obu_size, 32'd0);
    chk("t8_rst_width", 32'(bus.frame_width), 32'd0);
    chk("t8_rst_qindex", 32'(bus.qindex), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_beat(1'b1, 8'h1A, 8'h06, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t8_post_obu_valid", 32'(bus.obu_valid), 32'd1);
    chk("t8_post_obu_type", 32'(bus.obu_type), 32'd3);
    chk("t8_post_width", 32'(bus.frame_width), 32'd64);
    chk("t8_post_header_valid", 32'(bus.header_valid), 32'd1);
    chk("t8_post_error", 32'(bus.error), 32'd0);
    pulse_obu_ready();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/av2_obu_front_end.md
AV2_OBU_FRONT_END -- requirements
Module: av2_obu_front_end

Interface
REQ-001 Parameter DATA_WIDTH, default 128, is the input stream width in bits and SHALL be a multiple of 8, at least 96.
REQ-002 clk  input  1  the single clock; all logic is rising-edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 s_axis_tdata  input  DATA_WIDTH  bitstream beat; byte k = bits [8k+7:8k].
REQ-005 s_axis_tvalid  input  1  beat valid.
REQ-006 s_axis_tready  output  1  beat accepted when tvalid and tready are both 1.
REQ-007 s_axis_tlast  input  1  last beat of one OBU.
REQ-008 obu_type  output  4  parsed OBU type.
REQ-009 obu_size  output  32  decoded payload size in bytes.
REQ-010 obu_valid  output  1  OBU descriptor valid.
REQ-011 obu_ready  input  1  consumer accepts the descriptor.
REQ-012 frame_type  output  2  frame type: 0 KEY, 1 INTER, 2 INTRA_ONLY, 3 S.
REQ-013 frame_width  output  16  frame width in pixels.
REQ-014 frame_height  output  16  frame height in pixels.
REQ-015 qindex  output  8  base quantizer index.
REQ-016 header_valid  output  1  frame header fields valid.
REQ-017 header_ready  input  1  consumer accepts the header.
REQ-018 error  output  1  one-cycle pulse on a malformed OBU.

Function
REQ-019 The block SHALL implement three states: IDLE, HOLD and SKIP.
- IDLE: tready=1.
- HOLD: tready=0, obu_valid=1.
- SKIP: tready=1, discards beats.
REQ-020 IDLE: an accepted beat is the first beat of an OBU.
- Byte 0 is the OBU header: bit7 forbidden, bits[6:3] obu_type, bit2 extension_flag, bit1 has_size_field.
REQ-021 Payload offset p:
- Start at 1; add 1 when extension_flag is set (that byte is ignored).
- If has_size_field is set, decode LEB128 from byte p: 7 bits per byte, little-endian groups, continuation bit 7, at most 4 bytes; p advances past the size bytes.
- If has_size_field is clear, obu_size SHALL be 0.
REQ-022 A beat is malformed if the forbidden bit is set, or the 4th LEB128 byte has its continuation bit set. A malformed beat SHALL:
- pulse error for 1 cycle;
- leave obu_valid, header_valid and all field outputs unchanged;
- go to SKIP, or stay in IDLE if tlast=1.
REQ-023 On a good first beat, obu_type and obu_size SHALL be registered, obu_valid SHALL rise the next cycle, and the state SHALL become HOLD.
REQ-024 If obu_type is 3 (frame header) or 6 (frame), the header fields SHALL load in the same cycle as obu_type/obu_size, and header_valid SHALL rise together with obu_valid. Field layout from byte p:
- frame_type = byte p bits[1:0];
- width = {byte p+2, byte p+1} + 1;
- height = {byte p+4, byte p+3} + 1;
- qindex = byte p+5.
REQ-025 A width or height minus-one value of 0xFFFF SHALL saturate the output to 0xFFFF.
REQ-026 Other OBU types SHALL leave the header fields and header_valid unchanged.
REQ-027 HOLD: when obu_ready=1, obu_valid SHALL drop the next cycle. The next state is IDLE if the first beat had tlast=1, else SKIP.
REQ-028 SKIP: the block SHALL accept beats until a beat with tlast=1 is accepted, then return to IDLE.
REQ-029 header_valid SHALL stay high until a cycle with header_ready=1, then clear the next cycle.
REQ-030 If a new frame header loads in the same cycle that header_ready clears header_valid, the load SHALL win and header_valid SHALL stay 1.
REQ-031 An extra byte beyond the parsed fields SHALL be ignored.

Reset
REQ-032 While rst=1, the following outputs SHALL be 0 and the state SHALL be IDLE:
- s_axis_tready, obu_valid, header_valid, error;
- obu_type, obu_size, frame_type, frame_width, frame_height, qindex.
REQ-033 s_axis_tready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 Reset in HOLD or SKIP SHALL abandon the OBU with no error pulse.

Verification
REQ-035 Single beat, bytes 0x1A,0x06,0x00,0x3F,0x00,0x3F,0x00,0x80 with tlast=1 -> next cycle:
- obu_valid=1, obu_type=3, obu_size=6;
- frame_type=0, width=64, height=64, qindex=128, header_valid=1, tready=0.
REQ-036 Same OBU; hold obu_ready=0 for 5 cycles, then pulse obu_ready -> obu_valid stays 1 for those cycles, then clears, and tready returns to 1 (IDLE).
REQ-037 Bytes 0x36,0xXX,0xC8,0x01,0x01,0x7F,0x07,0x37,0x04,0xFF, then 3 more beats with tlast on the last -> obu_type=6, obu_size=200, frame_type=1, width=1920, height=1080, qindex=255; all 4 beats are consumed before IDLE.
REQ-038 Byte 0 = 0x0A (type 1, size 0x02) -> obu_type=1, obu_size=2; header_valid and the header fields are unchanged.
REQ-039 Byte 0 = 0x9A -> error pulses exactly 1 cycle, obu_valid stays 0, and the remaining beats are dropped to tlast.
REQ-040 Assert rst while in SKIP -> all outputs read 0 the next cycle; a following good OBU parses normally.
